// File: rtl/bias_memory_controller.sv
// Bias memory controller: arbitrates single-row writes and reads to a bias SRAM wrapper,
// registers the read word behind a valid/ready handshake and powers the macro down when idle.
module bias_memory_controller #(
    parameter int WIDTH         = 64,
    parameter int NUM_ROWS      = 32,
    parameter int IDLE_CYCLES   = 16,
    localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     auto_sleep_enable,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDRESS_WIDTH-1:0] wr_address,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [WIDTH-1:0]         wr_mask,
    input  logic                     rd_valid,
    output logic                     rd_ready,
    input  logic [ADDRESS_WIDTH-1:0] rd_address,
    output logic                     bias_valid,
    input  logic                     bias_ready,
    output logic [WIDTH-1:0]         bias_data,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0]         mem_data_in,
    output logic [WIDTH-1:0]         mem_mask,
    output logic                     mem_chip_select,
    output logic                     mem_write_enable,
    output logic                     mem_power_down,
    output logic                     mem_power_down_small_bias,
    input  logic [WIDTH-1:0]         mem_data_out
);

    localparam int COUNT_WIDTH = $clog2(IDLE_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] IDLE_MAX = COUNT_WIDTH'(IDLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        HOLD,
        SLEEP,
        WAKE
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   op_write;
    logic [COUNT_WIDTH-1:0] idle_count;
    logic                   accept_write;
    logic                   accept_read;
    logic                   idle_quiet;

    assign accept_write = (state == IDLE) && wr_valid;
    assign accept_read  = (state == IDLE) && !wr_valid && rd_valid;
    assign idle_quiet   = (state == IDLE) && !wr_valid && !rd_valid;

    assign wr_ready = (state == IDLE);
    assign rd_ready = (state == IDLE);
    assign mem_power_down_small_bias = mem_power_down;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wr_valid || rd_valid)
                    next_state = ISSUE;
                else if (idle_count == IDLE_MAX)
                    next_state = SLEEP;
            end
            ISSUE:   next_state = op_write ? IDLE : CAPTURE;
            CAPTURE: next_state = HOLD;
            HOLD:    next_state = bias_ready ? IDLE : HOLD;
            SLEEP:   next_state = (wr_valid || rd_valid) ? WAKE : SLEEP;
            WAKE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory-facing strobes are registered from next_state so they line up with ISSUE/SLEEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            op_write         <= 1'b0;
            idle_count       <= '0;
            bias_valid       <= 1'b0;
            bias_data        <= '0;
            mem_address      <= '0;
            mem_data_in      <= '0;
            mem_mask         <= '0;
            mem_chip_select  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_power_down   <= 1'b0;
        end else begin
            state            <= next_state;
            mem_chip_select  <= (next_state == ISSUE);
            mem_write_enable <= accept_write;
            mem_power_down   <= (next_state == SLEEP);
            bias_valid       <= (next_state == HOLD);

            if (accept_write) begin
                op_write    <= 1'b1;
                mem_address <= wr_address;
                mem_data_in <= wr_data;
                mem_mask    <= wr_mask;
            end else if (accept_read) begin
                op_write    <= 1'b0;
                mem_address <= rd_address;
            end

            if (state == CAPTURE)
                bias_data <= mem_data_out;

            if (idle_quiet && auto_sleep_enable) begin
                if (idle_count != IDLE_MAX)
                    idle_count <= idle_count + 1'b1;
            end else begin
                idle_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bias_memory_controller.sv
// Self-checking bench for bias_memory_controller: vector table, directed corner sequences
// and randomized traffic checked against a masked-write reference memory.
module tb_bias_memory_controller;

    localparam int W  = 64;
    localparam int NR = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          auto_sleep_enable = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_address = '0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  wr_mask = '0;
    logic          rd_valid = 1'b0;
    logic          rd_ready;
    logic [AW-1:0] rd_address = '0;
    logic          bias_valid;
    logic          bias_ready = 1'b0;
    logic [W-1:0]  bias_data;
    logic [AW-1:0] mem_address;
    logic [W-1:0]  mem_data_in;
    logic [W-1:0]  mem_mask;
    logic          mem_chip_select;
    logic          mem_write_enable;
    logic          mem_power_down;
    logic          mem_power_down_small_bias;
    logic [W-1:0]  mem_data_out = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [W-1:0] mem_model [NR] = '{default: '0};
    logic [W-1:0] ref_mem   [NR] = '{default: '0};

    bias_memory_controller #(
        .WIDTH(W),
        .NUM_ROWS(NR),
        .IDLE_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .auto_sleep_enable(auto_sleep_enable),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_address(wr_address),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_address(rd_address),
        .bias_valid(bias_valid),
        .bias_ready(bias_ready),
        .bias_data(bias_data),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .mem_mask(mem_mask),
        .mem_chip_select(mem_chip_select),
        .mem_write_enable(mem_write_enable),
        .mem_power_down(mem_power_down),
        .mem_power_down_small_bias(mem_power_down_small_bias),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // SRAM wrapper: bit-masked write, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_chip_select) begin
            if (mem_write_enable)
                mem_model[mem_address] <= (mem_model[mem_address] & ~mem_mask) | (mem_data_in & mem_mask);
            else
                mem_data_out <= mem_model[mem_address];
        end
    end

    typedef struct {
        bit           is_write;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic [W-1:0]  mask;
        int unsigned   stall;
        logic [W-1:0]  expect_data;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        wr_valid = 1'b1; wr_address = a; wr_data = d; wr_mask = m;
        check("wr_ready_idle", wr_ready, 1);
        step();
        wr_valid = 1'b0;
        wr_data = $urandom; wr_mask = $urandom;
        check("wr_cs", mem_chip_select, 1);
        check("wr_we", mem_write_enable, 1);
        check("wr_addr", mem_address, a);
        check("wr_data_out", mem_data_in, d);
        check("wr_mask_out", mem_mask, m);
        check("wr_ready_busy", wr_ready, 0);
        step();
        check("wr_cs_after", mem_chip_select, 0);
        check("wr_we_after", mem_write_enable, 0);
        check("wr_ready_back", wr_ready, 1);
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] exp, input int unsigned stall);
        rd_valid = 1'b1; rd_address = a; bias_ready = 1'b0;
        check("rd_ready_idle", rd_ready, 1);
        step();
        rd_valid = 1'b0;
        check("rd_cs", mem_chip_select, 1);
        check("rd_we", mem_write_enable, 0);
        check("rd_addr", mem_address, a);
        check("rd_ready_busy", rd_ready, 0);
        step();
        check("bias_valid_early", bias_valid, 0);
        check("rd_cs_capture", mem_chip_select, 0);
        step();
        check("bias_valid_t3", bias_valid, 1);
        check("bias_data", bias_data, exp);
        for (int unsigned i = 0; i < stall; i++) begin
            step();
            check("hold_valid", bias_valid, 1);
            check("hold_data", bias_data, exp);
            check("hold_rd_ready", rd_ready, 0);
        end
        bias_ready = 1'b1;
        step();
        bias_ready = 1'b0;
        check("bias_valid_drop", bias_valid, 0);
        check("rd_ready_back", rd_ready, 1);
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{1, 5'd5,  64'hDEAD_BEEF_0000_0001, '1,                     0,  '0});
        vecs.push_back('{0, 5'd5,  '0, '0,                                          0,  64'hDEAD_BEEF_0000_0001});
        vecs.push_back('{1, 5'd5,  64'h0,                   64'h0000_0000_FFFF_FFFF, 0, '0});
        vecs.push_back('{0, 5'd5,  '0, '0,                                          10, 64'hDEAD_BEEF_0000_0000});
        vecs.push_back('{1, 5'd31, '1,                      64'hF0F0_F0F0_F0F0_F0F0, 0, '0});
        vecs.push_back('{0, 5'd31, '0, '0,                                          2,  64'hF0F0_F0F0_F0F0_F0F0});
        vecs.push_back('{0, 5'd0,  '0, '0,                                          0,  64'h0});

        rst = 1'b1;
        step(); step();
        check("rst_bias_valid", bias_valid, 0);
        check("rst_bias_data", bias_data, 0);
        check("rst_cs", mem_chip_select, 0);
        check("rst_we", mem_write_enable, 0);
        check("rst_pd", mem_power_down, 0);
        check("rst_addr", mem_address, 0);
        check("rst_mask", mem_mask, 0);
        check("rst_wr_ready", wr_ready, 1);
        rst = 1'b0;
        step();

        foreach (vecs[i]) begin
            if (vecs[i].is_write)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].mask);
            else
                do_read(vecs[i].addr, vecs[i].expect_data, vecs[i].stall);
        end

        // Simultaneous requests: write first, read stays pending and is taken next IDLE cycle.
        wr_valid = 1'b1; wr_address = 5'd9; wr_data = 64'h0123_4567_89AB_CDEF; wr_mask = '1;
        rd_valid = 1'b1; rd_address = 5'd9;
        step();
        wr_valid = 1'b0;
        check("both_we", mem_write_enable, 1);
        check("both_cs", mem_chip_select, 1);
        step();
        check("both_idle_cs", mem_chip_select, 0);
        check("both_rd_ready", rd_ready, 1);
        ref_mem[9] = 64'h0123_4567_89AB_CDEF;
        do_read(5'd9, 64'h0123_4567_89AB_CDEF, 0);

        // Auto sleep after 16 counted idle cycles, then wake on a read.
        auto_sleep_enable = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            step();
            check("pd_before_timeout", mem_power_down, 0);
        end
        step();
        check("pd_asserted", mem_power_down, 1);
        check("pd_small_bias", mem_power_down_small_bias, 1);
        check("sleep_rd_ready", rd_ready, 0);
        auto_sleep_enable = 1'b0;
        repeat (5) step();
        check("pd_held_no_enable", mem_power_down, 1);
        rd_valid = 1'b1; rd_address = 5'd31;
        step();
        check("wake_pd", mem_power_down, 0);
        check("wake_cs", mem_chip_select, 0);
        check("wake_rd_ready", rd_ready, 0);
        step();
        check("post_wake_cs", mem_chip_select, 0);
        do_read(5'd31, ref_mem[31], 0);

        // Reset while in CAPTURE abandons the read.
        rd_valid = 1'b1; rd_address = 5'd5;
        step();
        rd_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstcap_valid", bias_valid, 0);
        check("rstcap_cs", mem_chip_select, 0);
        check("rstcap_pd", mem_power_down, 0);
        check("rstcap_addr", mem_address, 0);
        check("rstcap_data_in", mem_data_in, 0);
        check("rstcap_rd_ready", rd_ready, 1);
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            check("rstcap_no_valid", bias_valid, 0);
        end

        // Reset cleared the SRAM model's contents only in the controller, not the array.
        for (int unsigned n = 0; n < 150; n++) begin
            logic [AW-1:0] a;
            logic [W-1:0]  d, m;
            a = AW'($urandom_range(0, NR - 1));
            d = {$urandom, $urandom};
            m = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, m);
            else
                do_read(a, ref_mem[a], $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bias_memory_controller.md
BIAS_MEMORY_CONTROLLER -- requirements
Module: bias_memory_controller

Interface
REQ-001 Parameter WIDTH, default 64, bias word width in bits.
REQ-002 Parameter NUM_ROWS, default 32, bias memory depth; ADDRESS_WIDTH = clog2(NUM_ROWS).
REQ-003 Parameter IDLE_CYCLES, default 16, consecutive idle cycles before automatic power-down; minimum 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 auto_sleep_enable  input  1  1 = idle power-down permitted.
REQ-007 wr_valid / wr_ready  input / output  1 / 1  write request handshake.
REQ-008 wr_address / wr_data / wr_mask  input  ADDRESS_WIDTH / WIDTH / WIDTH  write row, data, bit-enable (1 = bit written).
REQ-009 rd_valid / rd_ready  input / output  1 / 1  read request handshake.
REQ-010 rd_address  input  ADDRESS_WIDTH  read row.
REQ-011 bias_valid / bias_ready  output / input  1 / 1  read-data handshake.
REQ-012 bias_data  output  WIDTH  registered read word.
REQ-013 mem_address / mem_data_in / mem_mask  output  ADDRESS_WIDTH / WIDTH / WIDTH  memory wrapper address, data, mask (1 = bit written).
REQ-014 mem_chip_select / mem_write_enable  output  1 / 1  active-high memory enable and write strobe.
REQ-015 mem_power_down / mem_power_down_small_bias  output  1 / 1  active-high memory power-down; both carry the same value.
REQ-016 mem_data_out  input  WIDTH  memory read data, valid the cycle after a read-enabled cycle.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD, SLEEP, WAKE; every memory-facing output SHALL be driven from registers only.
REQ-018 IDLE: wr_ready = rd_ready = 1; all other states: both 0.
REQ-019 IDLE, wr_valid=1: latch wr_address/wr_data/wr_mask, op = write, go to ISSUE; write has priority when wr_valid and rd_valid are both 1, and the read stays pending.
REQ-020 IDLE, rd_valid=1, wr_valid=0: latch rd_address, op = read, go to ISSUE.
REQ-021 ISSUE: mem_chip_select=1, mem_write_enable=(op==write), mem_address/data_in/mask = latched values; next state IDLE for a write, CAPTURE for a read.
REQ-022 Outside ISSUE: mem_chip_select=0 and mem_write_enable=0; mem_address, mem_data_in and mem_mask hold their last values.
REQ-023 CAPTURE: bias_data <= mem_data_out at the clock edge; next state HOLD.
REQ-024 HOLD: bias_valid=1 and bias_data stable until bias_ready=1; on handshake, go to IDLE and bias_valid=0 the next cycle.
REQ-025 Latency: a read accepted at edge t gives bias_valid=1 from cycle t+3; write throughput is 1 per 2 cycles; read throughput is 1 per 4 cycles when bias_ready is held at 1.
REQ-026 Idle counter (clog2(IDLE_CYCLES+1) bits): increments each IDLE cycle with wr_valid=rd_valid=0 and auto_sleep_enable=1; clears otherwise and in any non-IDLE state; saturates at IDLE_CYCLES.
REQ-027 IDLE, counter == IDLE_CYCLES and no request: next state SLEEP.
REQ-028 SLEEP: mem_power_down=1; wr_valid or rd_valid -> WAKE; requests are not accepted in SLEEP.
REQ-029 WAKE: mem_power_down=0, no memory access; next state IDLE; the pending request is accepted in IDLE.
REQ-030 auto_sleep_enable falling to 0 while in SLEEP SHALL NOT wake the block; only a request wakes it.
REQ-031 Address values >= NUM_ROWS are passed through unchanged; no range check.

Reset
REQ-032 rst=1 at an edge: state IDLE, idle counter 0, bias_valid=0, bias_data=0, mem_chip_select=0, mem_write_enable=0, mem_power_down=0, mem_address/data_in/mask=0.
REQ-033 Reset mid-transaction (ISSUE/CAPTURE/HOLD) SHALL abandon the operation; no bias_valid is produced for it.

Verification
REQ-034 Write addr 5, data 0xDEAD_BEEF_0000_0001, mask all-ones -> one ISSUE cycle with cs=1, we=1, address 5; wr_ready low exactly 1 cycle.
REQ-035 Read addr 5 after that write, bias_ready=1 -> bias_valid high at t+3 for 1 cycle, bias_data = written word (partial mask honoured by memory model).
REQ-036 wr_valid and rd_valid asserted together -> write issued first, read accepted on the next IDLE cycle.
REQ-037 bias_ready=0 for 10 cycles in HOLD -> bias_valid and bias_data stable, rd_ready=0 throughout.
REQ-038 auto_sleep_enable=1, IDLE_CYCLES=16, no requests -> mem_power_down rises after 16 idle cycles; rd_valid then -> one WAKE cycle, then accept; read returns correct data.
REQ-039 rst asserted in CAPTURE -> next cycle IDLE, bias_valid=0, all memory controls 0.
